if_id_stage: RTL and testbench

Fetch-to-decode pipeline stage sitting directly downstream of the program-counter register. It captures each fetched instruction with its address and address+4 into the IF/ID slot. It generates the PC write enable that drives the PC register's `En_Reg`. A one-entry skid buffer absorbs the instruction already in flight when decode stalls, and branch flushes are handled here.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/if_skid_buf.sv | 40 ++++
 rtl/if_id_stage.sv | 125 ++++++++++++
 tb/tb_if_id_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types and constants: entry struct, occupancy encoding,
// default bubble instruction and PC increment.
package pipe_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Builds a valid fetch entry; pc_plus4 wraps modulo 2^32.
  function automatic if_id_entry_t make_entry(input logic [31:0] pc, input logic [31:0] instr);
    if_id_entry_t e;
    e.pc       = pc;
    e.pc_plus4 = pc + PC_INCR;
    e.instr    = instr;
    e.valid    = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding the fetch that was already in flight when decode stalled.
module if_skid_buf
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  if_id_entry_t entry_i,
  output if_id_entry_t entry_o,
  output logic         valid_o
);

  if_id_entry_t entry_q, entry_d;

  // A simultaneous load and unload replaces the drained entry with the new fetch.
  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d.valid = 1'b0;
    end else if (load) begin
      entry_d = entry_i;
    end else if (unload) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = entry_q.valid;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline slot with one-entry skid buffer, PC write enable and flush handling.
// Optional stall/valid cycle counter on output Stall_Cnt when IF_ID_PERF_EN is defined.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC_In,
  input  logic [31:0] Instr_In,
  input  logic        IMem_Ready,
  input  logic        Stall,
  input  logic        Flush,
  output logic        En_PC,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Plus4_Out,
  output logic [31:0] Instr_Out,
  output logic        Valid_Out
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  occ_state_t   state_q, state_d;
  if_id_entry_t slot_q, slot_d;
  if_id_entry_t fetch_entry, skid_entry;
  logic         skid_valid, skid_load, skid_unload, accept;

  assign fetch_entry = make_entry(PC_In, Instr_In);

  if_skid_buf u_skid (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (Flush),
    .load    (skid_load),
    .unload  (skid_unload),
    .entry_i (fetch_entry),
    .entry_o (skid_entry),
    .valid_o (skid_valid)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= OCC_EMPTY;
      slot_q  <= '{pc: 32'd0, pc_plus4: PC_INCR, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (Flush) begin
      state_d = OCC_EMPTY;
      slot_d  = '{pc: 32'd0, pc_plus4: PC_INCR, instr: NOP_INSTR, valid: 1'b0};
    end else if (Stall) begin
      // An empty slot is filled directly so the skid is never valid without the slot.
      unique case (state_q)
        OCC_EMPTY: if (accept) begin
          slot_d  = fetch_entry;
          state_d = OCC_ONE;
        end
        OCC_ONE: if (accept) begin
          skid_load = 1'b1;
          state_d   = OCC_TWO;
        end
        default: ;
      endcase
    end else begin
      if (state_q == OCC_TWO) begin
        slot_d      = skid_entry;
        skid_load   = accept;
        skid_unload = ~accept;
        state_d     = accept ? OCC_TWO : OCC_ONE;
      end else if (accept) begin
        slot_d  = fetch_entry;
        state_d = OCC_ONE;
      end else begin
        slot_d.instr = NOP_INSTR;
        slot_d.valid = 1'b0;
        state_d      = OCC_EMPTY;
      end
    end
  end

  always_comb begin
    En_PC        = Flush | (IMem_Ready & (~Stall | ~skid_valid));
    accept       = IMem_Ready & En_PC;
    PC_Out       = slot_q.pc;
    PC_Plus4_Out = slot_q.pc_plus4;
    Instr_Out    = slot_q.instr;
    Valid_Out    = slot_q.valid;
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a real instruction is held by a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && slot_q.valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`else
  // Counter omitted: no Stall_Cnt port in this build.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage: the reference model tracks the
// fetched-but-unconsumed instructions as a FIFO and the PC register as a variable.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        Rst, IMem_Ready, Stall, Flush;
  logic [31:0] PC_In, Instr_In;
  logic        En_PC, Valid_Out;
  logic [31:0] PC_Out, PC_Plus4_Out, Instr_Out;
`ifdef IF_ID_PERF_EN
  logic [31:0] Stall_Cnt;
`endif

  always #5 clk = ~clk;

  if_id_stage #(.NOP_INSTR(NOP)) dut (
    .Clk          (clk),
    .Rst          (Rst),
    .PC_In        (PC_In),
    .Instr_In     (Instr_In),
    .IMem_Ready   (IMem_Ready),
    .Stall        (Stall),
    .Flush        (Flush),
    .En_PC        (En_PC),
    .PC_Out       (PC_Out),
    .PC_Plus4_Out (PC_Plus4_Out),
    .Instr_Out    (Instr_Out),
    .Valid_Out    (Valid_Out)
`ifdef IF_ID_PERF_EN
    ,
    .Stall_Cnt    (Stall_Cnt)
`endif
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          checking = 1'b0;
  logic [31:0] pc_reg = 32'd0;
  logic [31:0] flush_target = 32'h0000_0100;
  logic [31:0] last_pc = 32'd0;
  logic [31:0] last_pc4 = 32'd4;
  logic [31:0] cnt_model = 32'd0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Registered outputs and the combinational PC enable versus the model.
  task automatic checkOutput(input logic exp_en);
    compare("en_pc", {31'd0, En_PC}, {31'd0, exp_en});
    compare("valid_out", {31'd0, Valid_Out}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() == 0) begin
      compare("bubble_pc", PC_Out, last_pc);
      compare("bubble_pc4", PC_Plus4_Out, last_pc4);
      compare("bubble_instr", Instr_Out, NOP);
    end
`ifdef IF_ID_PERF_EN
    compare("stall_cnt", Stall_Cnt, cnt_model);
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic st, input logic fl);
    logic exp_en;
    exp_t e;
    @(negedge clk);
    Rst        = r;
    IMem_Ready = rdy;
    Stall      = st;
    Flush      = fl;
    PC_In      = pc_reg;
    Instr_In   = $urandom;
    #1;
    exp_en = fl | (rdy & (~st | (exp_q.size() < 2)));
    if (checking) checkOutput(exp_en);
    if (exp_q.size() > 0) begin
      last_pc  = exp_q[0].pc;
      last_pc4 = exp_q[0].pc4;
    end
    if (r) cnt_model = 32'd0;
    else if (st && exp_q.size() > 0 && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
    if (r) begin
      exp_q.delete();
      last_pc  = 32'd0;
      last_pc4 = 32'd4;
      pc_reg   = 32'd0;
    end else if (fl) begin
      exp_q.delete();
      last_pc  = 32'd0;
      last_pc4 = 32'd4;
      pc_reg   = flush_target;
    end else if (rdy && exp_en) begin
      e.pc    = PC_In;
      e.pc4   = PC_In + 32'd4;
      e.instr = Instr_In;
      exp_q.push_back(e);
      pc_reg  = pc_reg + 32'd4;
    end
  endtask

  // Monitor: a slot consumed by decode must be the oldest outstanding fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (checking && !Rst && !Flush && !Stall && Valid_Out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL consume_unexpected actual=pc %h required=no instruction", PC_Out);
        end else begin
          e = exp_q.pop_front();
          compare("slot_pc", PC_Out, e.pc);
          compare("slot_pc4", PC_Plus4_Out, e.pc4);
          compare("slot_instr", Instr_Out, e.instr);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    Rst = 1'b1; IMem_Ready = 1'b0; Stall = 1'b0; Flush = 1'b0;
    PC_In = 32'd0; Instr_In = 32'd0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checking = 1'b1;
    // reset state, then streaming fetches
    applyStimulus(0, 1, 0, 0);
    repeat (4) applyStimulus(0, 1, 0, 0);
    // three-cycle stall with fetches pending, then release and drain
    repeat (3) applyStimulus(0, 1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0, 0);
    // fill slot and skid, then flush
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 1);
    repeat (2) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    repeat (2) applyStimulus(0, 1, 0, 0);
    // instruction memory not ready: bubbles with held PC fields
    repeat (2) applyStimulus(0, 0, 0, 0);
    // address wrap at the top of the address space
    flush_target = 32'hFFFF_FFF0;
    applyStimulus(0, 1, 0, 1);
    repeat (6) applyStimulus(0, 1, 0, 0);
    // five stalled valid cycles, then reset with the skid full
    repeat (5) applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    repeat (3) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      flush_target = t;
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                    ($urandom_range(2) == 0), ($urandom_range(9) == 0));
    end
    repeat (4) applyStimulus(0, 0, 0, 0);
    compare("drain_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
